frame_decimator: RTL

- Downstream neighbour of the duplicator. Consumes its AXI-Stream-style beat stream (TDATA/TVALID/TREADY/TUSER) and forwards one frame out of every KEEP_N; the other frames are discarded.
- Frame boundaries come from i_TUSER[0] (start-of-frame). i_TUSER[1] (line marker) passes through untouched.
- Output is registered through a 2-entry skid buffer, so full throughput is kept under backpressure.

---
 rtl/frame_decimator.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/frame_decimator.sv
// frame_decimator: forwards one frame in KEEP_N of a TUSER[0]-framed beat stream.
// Define FRAME_DECIM_STATS_EN to add the o_drop_cnt / o_frame_cnt counters.
module frame_decimator #(
    parameter int DATA_W = 4,
    parameter int USER_W = 2,
    parameter int KEEP_N = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] i_TDATA,
    input  logic              i_TVALID,
    input  logic [USER_W-1:0] i_TUSER,
    input  logic              i_TREADY,
    output logic              o_TREADY,
    output logic [DATA_W-1:0] o_TDATA,
    output logic              o_TVALID,
`ifdef FRAME_DECIM_STATS_EN
    output logic [15:0]       o_drop_cnt,
    output logic [15:0]       o_frame_cnt,
`endif
    output logic [USER_W-1:0] o_TUSER
);

    localparam logic [7:0] IDX_LAST  = 8'(KEEP_N - 1);
    localparam logic [7:0] IDX_FIRST = (KEEP_N == 1) ? 8'd0 : 8'd1;

    typedef enum logic [1:0] {
        WAIT_SOF,
        PASS,
        DROP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  idx_q;
    logic [7:0]  idx_d;
    logic [7:0]  idx_inc;
    logic        sof_q;
    logic        accept;
    logic        boundary;
    logic        fwd;

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic [USER_W-1:0] main_u;
    logic              skid_v;
    logic [DATA_W-1:0] skid_d;
    logic [USER_W-1:0] skid_u;
    logic              rdy_q;

    logic              main_v_n;
    logic [DATA_W-1:0] main_d_n;
    logic [USER_W-1:0] main_u_n;
    logic              skid_v_n;
    logic [DATA_W-1:0] skid_d_n;
    logic [USER_W-1:0] skid_u_n;
    logic              take;

    assign accept   = i_TVALID & rdy_q;
    // A held SOF level belongs to one frame: only the rising level counts.
    assign boundary = accept & i_TUSER[0] & ~sof_q;
    assign idx_inc  = (idx_q == IDX_LAST) ? 8'd0 : idx_q + 8'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fwd     = 1'b0;
        unique case (state_q)
            WAIT_SOF: begin
                if (boundary) begin
                    state_d = PASS;
                    idx_d   = IDX_FIRST;
                    fwd     = 1'b1;
                end
            end
            PASS, DROP: begin
                if (boundary) begin
                    idx_d = idx_inc;
                    if (idx_q == 8'd0) begin
                        state_d = PASS;
                        fwd     = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end else begin
                    fwd = accept & (state_q == PASS);
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= WAIT_SOF;
            idx_q   <= 8'd0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                sof_q <= i_TUSER[0];
            end
        end
    end

    assign take = main_v & i_TREADY;

    always_comb begin
        main_v_n = main_v;
        main_d_n = main_d;
        main_u_n = main_u;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        skid_u_n = skid_u;
        unique case (1'b1)
            take & skid_v: begin
                main_d_n = skid_d;
                main_u_n = skid_u;
                skid_v_n = 1'b0;
            end
            take & ~skid_v & fwd: begin
                main_d_n = i_TDATA;
                main_u_n = i_TUSER;
            end
            take & ~skid_v & ~fwd: begin
                main_v_n = 1'b0;
            end
            ~take & fwd & main_v: begin
                skid_v_n = 1'b1;
                skid_d_n = i_TDATA;
                skid_u_n = i_TUSER;
            end
            ~take & fwd & ~main_v: begin
                main_v_n = 1'b1;
                main_d_n = i_TDATA;
                main_u_n = i_TUSER;
            end
            default: ;
        endcase
    end

    // Ready is registered so upstream sees it drop one cycle after a stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_v <= 1'b0;
            main_d <= '0;
            main_u <= '0;
            skid_v <= 1'b0;
            skid_d <= '0;
            skid_u <= '0;
            rdy_q  <= 1'b0;
        end else begin
            main_v <= main_v_n;
            main_d <= main_d_n;
            main_u <= main_u_n;
            skid_v <= skid_v_n;
            skid_d <= skid_d_n;
            skid_u <= skid_u_n;
            rdy_q  <= ~skid_v_n;
        end
    end

    assign o_TREADY = rdy_q;
    assign o_TVALID = main_v;
    assign o_TDATA  = main_d;
    assign o_TUSER  = main_u;

`ifdef FRAME_DECIM_STATS_EN
    logic [15:0] drop_q;
    logic [15:0] frame_q;
    logic        drop_evt;

    assign drop_evt = boundary & (state_q != WAIT_SOF) & (idx_q != 8'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_q  <= 16'd0;
            frame_q <= 16'd0;
        end else begin
            if (boundary) begin
                frame_q <= frame_q + 16'd1;
            end
            if (drop_evt && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign o_drop_cnt  = drop_q;
    assign o_frame_cnt = frame_q;
`endif

endmodule
